// File: rtl/enable_sequencer.sv
// enable_sequencer: rate-divided enable pulse generator for the perf-test
// counter. Issues either a fixed-length burst of enables or a continuous
// stream under start/stop control, and reports progress and completion.
module enable_sequencer #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [WIDTH-1:0]     i_burst_len,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_enable,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [WIDTH-1:0]     o_pulses_issued
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     W_ONE = WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] D_ONE = DIV_WIDTH'(1);

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_pre;
  logic [DIV_WIDTH-1:0] r_div_q;
  logic [WIDTH-1:0]     r_burst_q;
  logic [WIDTH-1:0]     r_issued;

  // An enable fires on the last prescaler step of each div_q+1 cycle period.
  logic w_fire;
  logic w_last;

  // Decode the enable condition and the burst-complete condition from registers.
  always_comb begin
    w_fire = (r_state == RUN) && (r_pre == r_div_q);
    w_last = (r_burst_q != '0) && (r_issued == (r_burst_q - W_ONE));
  end

  // Sequencer FSM with prescaler, pulse counter and run-parameter latches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_pre     <= '0;
      r_div_q   <= '0;
      r_burst_q <= '0;
      r_issued  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // stop takes precedence over a simultaneous start
          if (i_start && !i_stop) begin
            r_state   <= RUN;
            r_burst_q <= i_burst_len;
            r_div_q   <= i_div;
            r_pre     <= '0;
            r_issued  <= '0;
          end
        end
        RUN: begin
          // prescaler wraps on match; equal-width compare so max div is safe
          if (w_fire) begin
            r_pre    <= '0;
            r_issued <= r_issued + W_ONE;
          end else begin
            r_pre <= r_pre + D_ONE;
          end
          // stop aborts without done even if this was the final enable
          if (i_stop) begin
            r_state <= IDLE;
          end else if (w_fire && w_last) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // single-cycle completion marker; start/stop deliberately ignored
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of state registers, so reset clears them at once.
  always_comb begin
    o_enable        = w_fire;
    o_busy          = (r_state == RUN);
    o_done          = (r_state == DONE);
    o_pulses_issued = r_issued;
  end

endmodule

// File: tb/tb_enable_sequencer.sv
// Directed testbench for enable_sequencer. Inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_enable_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [7:0] burst_len;
  logic [7:0] div;
  logic       enable;
  logic       busy;
  logic       done;
  logic [7:0] pulses_issued;

  int checks;
  int errors;

  enable_sequencer #(.WIDTH(8), .DIV_WIDTH(8)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_stop          (stop),
    .i_burst_len     (burst_len),
    .i_div           (div),
    .o_enable        (enable),
    .o_busy          (busy),
    .o_done          (done),
    .o_pulses_issued (pulses_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; burst_len = 0; div = 0;
    repeat (2) tick();
    checks++;
    if ({enable, busy, done, pulses_issued} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {enable, busy, done, pulses_issued});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_burst_div0();
    burst_len = 8'd4; div = 8'd0; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (enable !== 1'b1 || busy !== 1'b1 || pulses_issued !== 8'(i)) begin
        errors++;
        $display("FAIL burst0_cycle%0d: en=%b busy=%b issued=%0d expected en=1 busy=1 issued=%0d",
                 i, enable, busy, pulses_issued, i);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || enable !== 1'b0 || pulses_issued !== 8'd4) begin
      errors++;
      $display("FAIL burst0_done: done=%b busy=%b en=%b issued=%0d expected 1 0 0 4",
               done, busy, enable, pulses_issued);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pulses_issued !== 8'd4) begin
      errors++;
      $display("FAIL burst0_after: done=%b busy=%b issued=%0d expected 0 0 4", done, busy, pulses_issued);
    end
    $display("test_burst_div0 done");
  endtask

  task automatic test_burst_div2();
    logic exp_en;
    burst_len = 8'd3; div = 8'd2; start = 1;
    tick();
    start = 0;
    burst_len = 8'd50; div = 8'd7; // must not be re-sampled mid-run
    for (int c = 1; c <= 9; c++) begin
      exp_en = (c % 3 == 0);
      checks++;
      if (enable !== exp_en || busy !== 1'b1) begin
        errors++;
        $display("FAIL div2_cycle%0d: en=%b busy=%b expected en=%b busy=1", c, enable, busy, exp_en);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || pulses_issued !== 8'd3 || enable !== 1'b0) begin
      errors++;
      $display("FAIL div2_done: done=%b issued=%0d en=%b expected 1 3 0", done, pulses_issued, enable);
    end
    tick();
    $display("test_burst_div2 done");
  endtask

  task automatic test_continuous();
    int saw_done;
    saw_done = 0;
    burst_len = 8'd0; div = 8'd0; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 300; k++) begin
      if (k == 256) chk("cont_wrap", pulses_issued, 0);
      if (done !== 1'b0) saw_done++;
      tick();
    end
    chk("cont_no_done", saw_done, 0);
    chk("cont_issued_44", pulses_issued, 44);
    chk("cont_busy", busy, 1);
    stop = 1;
    tick();
    stop = 0;
    chk("cont_stop_busy", busy, 0);
    chk("cont_stop_issued", pulses_issued, 45);
    $display("test_continuous done");
  endtask

  task automatic test_stop();
    burst_len = 8'd10; div = 8'd0; start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    chk("stop_pre_issued", pulses_issued, 4);
    stop = 1;
    tick();
    stop = 0;
    chk("stop_issued", pulses_issued, 5);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    tick();
    chk("stop_done_later", done, 0);
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    chk("start_stop_idle", busy, 0);
    chk("start_stop_issued", pulses_issued, 5);
    $display("test_stop done");
  endtask

  task automatic test_async_reset();
    burst_len = 8'd0; div = 8'd0; start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    chk("areset_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_enable", enable, 0);
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    chk("areset_issued", pulses_issued, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    burst_len = 8'd2; div = 8'd0; start = 1;
    tick();
    start = 0;
    tick();
    tick();
    chk("areset_rerun_done", done, 1);
    chk("areset_rerun_issued", pulses_issued, 2);
    tick();
    $display("test_async_reset done");
  endtask

  task automatic test_back_to_back();
    logic exp_en;
    burst_len = 8'd2; div = 8'd1; start = 1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      exp_en = (c % 2 == 0);
      checks++;
      if (enable !== exp_en || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_cycle%0d: en=%b busy=%b expected en=%b busy=1", c, enable, busy, exp_en);
      end
      tick();
    end
    chk("b2b_done", done, 1);
    chk("b2b_done_busy", busy, 0);
    tick();
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_done", done, 0);
    chk("b2b_idle_issued", pulses_issued, 2);
    tick();
    start = 0;
    chk("b2b_rerun_busy", busy, 1);
    chk("b2b_rerun_issued", pulses_issued, 0);
    stop = 1;
    tick();
    stop = 0;
    $display("test_back_to_back done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 0; stop = 0; burst_len = 0; div = 0;
    test_reset();
    test_burst_div0();
    test_burst_div2();
    test_continuous();
    test_stop();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
